data_memory_responder: RTL and testbench

- Responder end of the core's data-memory interface. Accepts the load/store requests the datapath issues: read/write enable, address, write data and funct3 format.
- Serves each request from an internal word-organised synchronous RAM, with a valid/ready request handshake and a one-cycle response pulse.
- Performs byte-lane steering for stores and alignment, sign/zero extension for loads.
- Splits misaligned accesses that span two words into two RAM cycles, and flags out-of-range or illegal requests.

---
 rtl/data_memory_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Responder for the core's data-memory port: word-organised synchronous RAM with
// byte-lane steering, load extension and two-cycle handling of word-spanning accesses.
module data_memory_responder #(
  parameter int          ADDR_WIDTH       = 10,
  parameter logic [31:0] BASE_ADDRESS     = 32'h1001_0000,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_write_data,
  input  logic [2:0]  data_mem_format,
  output logic        response_valid,
  output logic [31:0] data_mem_data_fetched,
  output logic        access_fault
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS_LO = 2'd1,
    ACCESS_HI = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  state_t                  state_r, state_next_s;
  logic [ADDR_WIDTH-1:0]   lo_word_r;
  logic [1:0]              byte_r;
  logic [2:0]              format_r;
  logic                    is_store_r;
  logic                    span_r;
  logic [31:0]             wdata_r;
  logic [31:0]             lo_data_r;
  logic [31:0]             ram_q_r;
  logic                    resp_valid_r;
  logic                    fault_r;
  logic [31:0]             mem_r [0:(1<<ADDR_WIDTH)-1];

  logic [31:0]             offset_s;
  logic [ADDR_WIDTH-1:0]   req_lo_word_s;
  logic [1:0]              req_byte_s;
  logic [2:0]              req_size_s;
  logic                    req_span_s;
  logic                    req_fault_s;
  logic                    accept_s;
  logic [3:0]              size_mask_s;
  logic [4:0]              shamt_s;
  logic [63:0]             wide_data_s;
  logic [7:0]              wide_mask_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_s;
  logic [3:0]              ram_be_s;
  logic [31:0]             ram_wdata_s;
  logic                    ram_re_s;
  logic [63:0]             load_pair_s;
  logic [31:0]             load_word_s;
  logic [31:0]             load_ext_s;

  // Addresses below the base wrap to huge offsets and so fall into the range fault.
  assign offset_s      = data_mem_address - BASE_ADDRESS;
  assign req_lo_word_s = offset_s[ADDR_WIDTH+1:2];
  assign req_byte_s    = offset_s[1:0];
  assign req_span_s    = ({1'b0, req_byte_s} + req_size_s) > 3'd4;
  assign accept_s      = request_valid && request_ready;
  assign request_ready = reset && (state_r == IDLE);

  // Request size in bytes from the incoming format.
  always_comb begin
    req_size_s = 3'd4;
    case (data_mem_format[1:0])
      2'b00:   req_size_s = 3'd1;
      2'b01:   req_size_s = 3'd2;
      default: req_size_s = 3'd4;
    endcase
  end

  // Legality of the incoming request, evaluated at acceptance.
  always_comb begin
    req_fault_s = 1'b0;
    if (|offset_s[31:ADDR_WIDTH+2]) begin
      req_fault_s = 1'b1;
    end else if (req_span_s && (&req_lo_word_s)) begin
      req_fault_s = 1'b1;
    end else if ((data_mem_format == 3'b011) || (data_mem_format[2:1] == 2'b11)) begin
      req_fault_s = 1'b1;
    end else if (data_mem_write_enable && data_mem_format[2]) begin
      req_fault_s = 1'b1;
    end else if (data_mem_read_enable == data_mem_write_enable) begin
      req_fault_s = 1'b1;
    end else if (req_span_s && !ALLOW_MISALIGNED) begin
      req_fault_s = 1'b1;
    end else begin
      req_fault_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = req_fault_s ? RESPOND : ACCESS_LO;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS_LO: state_next_s = span_r ? ACCESS_HI : RESPOND;
      ACCESS_HI: state_next_s = RESPOND;
      RESPOND:   state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
  end

  // State, request latch and response flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      lo_word_r    <= '0;
      byte_r       <= 2'd0;
      format_r     <= 3'd0;
      is_store_r   <= 1'b0;
      span_r       <= 1'b0;
      wdata_r      <= 32'h0;
      lo_data_r    <= 32'h0;
      resp_valid_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      resp_valid_r <= (state_next_s == RESPOND);
      fault_r      <= accept_s && req_fault_s;
      if (accept_s) begin
        lo_word_r  <= req_lo_word_s;
        byte_r     <= req_byte_s;
        format_r   <= data_mem_format;
        is_store_r <= data_mem_write_enable;
        span_r     <= req_span_s;
        wdata_r    <= data_mem_write_data;
      end
      if (state_r == ACCESS_HI) begin
        lo_data_r <= ram_q_r;
      end
    end
  end

  // Byte-lane mask for the latched access size, before shifting to the byte offset.
  always_comb begin
    size_mask_s = 4'b1111;
    case (format_r[1:0])
      2'b00:   size_mask_s = 4'b0001;
      2'b01:   size_mask_s = 4'b0011;
      default: size_mask_s = 4'b1111;
    endcase
  end

  // Store data and mask span a 64-bit window; the upper half lands in the hi word.
  assign shamt_s     = {byte_r, 3'b000};
  assign wide_data_s = {32'h0, wdata_r} << shamt_s;
  assign wide_mask_s = {4'h0, size_mask_s} << byte_r;

  // RAM port control per access phase.
  always_comb begin
    ram_addr_s  = lo_word_r;
    ram_be_s    = 4'h0;
    ram_wdata_s = wide_data_s[31:0];
    ram_re_s    = 1'b0;
    case (state_r)
      ACCESS_LO: begin
        ram_addr_s  = lo_word_r;
        ram_be_s    = is_store_r ? wide_mask_s[3:0] : 4'h0;
        ram_wdata_s = wide_data_s[31:0];
        ram_re_s    = !is_store_r;
      end
      ACCESS_HI: begin
        ram_addr_s  = lo_word_r + ADDR_WIDTH'(1);
        ram_be_s    = is_store_r ? wide_mask_s[7:4] : 4'h0;
        ram_wdata_s = wide_data_s[63:32];
        ram_re_s    = !is_store_r;
      end
      default: begin
        ram_addr_s  = lo_word_r;
        ram_be_s    = 4'h0;
        ram_wdata_s = wide_data_s[31:0];
        ram_re_s    = 1'b0;
      end
    endcase
  end

  // Single-port RAM: per-byte writes, registered read; contents survive reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_be_s[i]) begin
        mem_r[ram_addr_s][8*i +: 8] <= ram_wdata_s[8*i +: 8];
      end
    end
    if (ram_re_s) begin
      ram_q_r <= mem_r[ram_addr_s];
    end
  end

  assign load_pair_s = span_r ? {ram_q_r, lo_data_r} : {32'h0, ram_q_r};
  assign load_word_s = load_pair_s[shamt_s +: 32];

  // Sign or zero extension of the aligned load bytes.
  always_comb begin
    load_ext_s = 32'h0;
    case (format_r)
      3'b000:  load_ext_s = {{24{load_word_s[7]}}, load_word_s[7:0]};
      3'b001:  load_ext_s = {{16{load_word_s[15]}}, load_word_s[15:0]};
      3'b010:  load_ext_s = load_word_s;
      3'b100:  load_ext_s = {24'h0, load_word_s[7:0]};
      3'b101:  load_ext_s = {16'h0, load_word_s[15:0]};
      default: load_ext_s = 32'h0;
    endcase
  end

  // Load data only arrives from the RAM on the edge entering RESPOND, so it is gated from registers here.
  assign data_mem_data_fetched = (resp_valid_r && !fault_r && !is_store_r) ? load_ext_s : 32'h0;
  assign response_valid        = resp_valid_r;
  assign access_fault          = fault_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed testbench for data_memory_responder: word/byte/half accesses, spanning
// accesses, faults (including a no-misaligned instance) and reset during an access.
module tb_data_memory_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [2:0]  fmt = 3'b000;
  logic        ready_a, ready_b, resp_a, resp_b, fault_a, fault_b;
  logic [31:0] data_a, data_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_memory_responder dut (
    .clock(clock), .reset(reset), .request_valid(valid_a), .request_ready(ready_a),
    .data_mem_read_enable(rd), .data_mem_write_enable(wr), .data_mem_address(addr),
    .data_mem_write_data(wdata), .data_mem_format(fmt), .response_valid(resp_a),
    .data_mem_data_fetched(data_a), .access_fault(fault_a)
  );

  data_memory_responder #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clock(clock), .reset(reset), .request_valid(valid_b), .request_ready(ready_b),
    .data_mem_read_enable(rd), .data_mem_write_enable(wr), .data_mem_address(addr),
    .data_mem_write_data(wdata), .data_mem_format(fmt), .response_valid(resp_b),
    .data_mem_data_fetched(data_b), .access_fault(fault_b)
  );

  // Issue one request, then count cycles after the acceptance edge until response_valid.
  task automatic do_req(input bit strict, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        output int lat, output logic [31:0] got, output logic flt);
    @(negedge clock);
    rd = r; wr = w; addr = a; wdata = d; fmt = f;
    if (strict) valid_b = 1'b1;
    else        valid_a = 1'b1;
    @(posedge clock);
    #1;
    valid_a = 1'b0; valid_b = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD; fmt = 3'b111;
    lat = 0; got = 32'h0; flt = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (strict ? resp_b : resp_a) begin
        lat = n;
        got = strict ? data_b : data_a;
        flt = strict ? fault_b : fault_a;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_a); end
    checks++; if (resp_a !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b expected 0", resp_a); end
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_a); end
    checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault_a); end
    reset = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", ready_a); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] got; logic flt;
    do_req(1'b0, 1'b0, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, F_W, lat, got, flt);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (got !== 32'h0 || flt !== 1'b0) begin errors++; $display("FAIL sw_resp: got data %h fault %b expected 0/0", got, flt); end
    do_req(1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0, F_W, lat, got, flt);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (got !== 32'hDEAD_BEEF || flt !== 1'b0) begin errors++; $display("FAIL lw_data: got %h fault %b expected deadbeef/0", got, flt); end
  endtask

  task automatic test_extension();
    int lat; logic [31:0] got; logic flt;
    logic [31:0] addrs [5];
    logic [2:0]  fmts  [5];
    logic [31:0] exps  [5];
    addrs = '{32'h1001_0003, 32'h1001_0003, 32'h1001_0002, 32'h1001_0002, 32'h1001_0000};
    fmts  = '{F_B, F_BU, F_H, F_HU, F_B};
    exps  = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_DEAD, 32'hFFFF_FFEF};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 1'b1, 1'b0, addrs[i], 32'h0, fmts[i], lat, got, flt);
      checks++;
      if (got !== exps[i] || lat !== 2 || flt !== 1'b0) begin
        errors++;
        $display("FAIL ext_%0d: got data %h lat %0d fault %b expected %h/2/0", i, got, lat, flt, exps[i]);
      end
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] got; logic flt;
    do_req(1'b0, 1'b0, 1'b1, 32'h1001_0001, 32'h1234_5655, F_B, lat, got, flt);
    do_req(1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0, F_W, lat, got, flt);
    checks++; if (got !== 32'hDEAD_55EF) begin errors++; $display("FAIL sb_lane: got %h expected dead55ef", got); end
    do_req(1'b0, 1'b0, 1'b1, 32'h1001_0002, 32'hAAAA_1234, F_H, lat, got, flt);
    do_req(1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0, F_W, lat, got, flt);
    checks++; if (got !== 32'h1234_55EF) begin errors++; $display("FAIL sh_lane: got %h expected 123455ef", got); end
  endtask

  task automatic test_span();
    int lat; logic [31:0] got; logic flt;
    logic [31:0] addrs [4];
    logic [2:0]  fmts  [4];
    logic [31:0] exps  [4];
    int          lats  [4];
    do_req(1'b0, 1'b0, 1'b1, 32'h1001_0004, 32'h0, F_W, lat, got, flt);
    do_req(1'b0, 1'b0, 1'b1, 32'h1001_0008, 32'h0, F_W, lat, got, flt);
    do_req(1'b0, 1'b0, 1'b1, 32'h1001_0006, 32'h1122_3344, F_W, lat, got, flt);
    checks++; if (lat !== 3 || flt !== 1'b0) begin errors++; $display("FAIL span_sw_latency: got %0d fault %b expected 3/0", lat, flt); end
    addrs = '{32'h1001_0004, 32'h1001_0008, 32'h1001_0006, 32'h1001_0007};
    fmts  = '{F_W, F_W, F_W, F_H};
    exps  = '{32'h3344_0000, 32'h0000_1122, 32'h1122_3344, 32'h0000_2233};
    lats  = '{2, 2, 3, 3};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b1, 1'b0, addrs[i], 32'h0, fmts[i], lat, got, flt);
      checks++;
      if (got !== exps[i] || lat !== lats[i] || flt !== 1'b0) begin
        errors++;
        $display("FAIL span_ld_%0d: got data %h lat %0d fault %b expected %h/%0d/0", i, got, lat, flt, exps[i], lats[i]);
      end
    end
  endtask

  task automatic test_faults();
    int lat; logic [31:0] got; logic flt;
    logic [31:0] addrs [6];
    logic [2:0]  fmts  [6];
    bit          rds   [6];
    bit          wrs   [6];
    addrs = '{32'h1000_FFFC, 32'h1001_1000, 32'h1001_0FFE, 32'h1001_0000, 32'h1001_0000, 32'h1001_0000};
    fmts  = '{F_W, F_W, F_W, 3'b011, F_BU, F_W};
    rds   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    wrs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, rds[i], wrs[i], addrs[i], 32'hFFFF_FFFF, fmts[i], lat, got, flt);
      checks++;
      if (flt !== 1'b1 || got !== 32'h0 || lat !== 1) begin
        errors++;
        $display("FAIL fault_%0d: got fault %b data %h lat %0d expected 1/0/1", i, flt, got, lat);
      end
    end
    do_req(1'b1, 1'b1, 1'b0, 32'h1001_0002, 32'h0, F_W, lat, got, flt);
    checks++; if (flt !== 1'b1 || got !== 32'h0 || lat !== 1) begin errors++; $display("FAIL fault_misaligned: got fault %b data %h lat %0d expected 1/0/1", flt, got, lat); end
    do_req(1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0, F_W, lat, got, flt);
    checks++; if (got !== 32'h1234_55EF) begin errors++; $display("FAIL fault_mem_unchanged: got %h expected 123455ef", got); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] got; logic flt;
    do_req(1'b0, 1'b0, 1'b1, 32'h1001_000C, 32'h0, F_W, lat, got, flt);
    do_req(1'b0, 1'b0, 1'b1, 32'h1001_0010, 32'h5566_7788, F_W, lat, got, flt);
    @(negedge clock);
    rd = 1'b0; wr = 1'b1; addr = 32'h1001_000E; wdata = 32'hCAFE_F00D; fmt = F_W; valid_a = 1'b1;
    @(posedge clock);
    #1;
    valid_a = 1'b0; wr = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (resp_a !== 1'b0 || data_a !== 32'h0 || fault_a !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got resp %b data %h fault %b expected 0", resp_a, data_a, fault_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", ready_a); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b1 || resp_a !== 1'b0) begin errors++; $display("FAIL post_reset_ready: got ready %b resp %b expected 1/0", ready_a, resp_a); end
    do_req(1'b0, 1'b1, 1'b0, 32'h1001_000C, 32'h0, F_W, lat, got, flt);
    checks++; if (got[31:16] !== 16'hF00D || got !== 32'hF00D_0000) begin errors++; $display("FAIL mid_reset_lo: got %h expected f00d0000", got); end
    do_req(1'b0, 1'b1, 1'b0, 32'h1001_0010, 32'h0, F_W, lat, got, flt);
    checks++; if (got !== 32'h5566_7788) begin errors++; $display("FAIL mid_reset_hi: got %h expected 55667788", got); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extension();
    test_byte_lanes();
    test_span();
    test_faults();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
